cpu_step_ctrl: RTL and testbench

//  Run/step/breakpoint controller directly upstream of the processor top.
//  - Debounces the board step button and run switch.
//  - Produces cpu_en, which is the write enable for the PC, the register file and DMEM. SYS_clk is never gated.
//  - Allows single-instruction stepping, free running, and halting on a PC breakpoint.
//  - Its status and instruction count feed the LED/hex debug select mux.

---
 rtl/cpu_step_ctrl_pkg.sv | 22 ++
 rtl/cpu_step_ctrl_if.sv | 31 +++
 rtl/cpu_step_ctrl_debounce.sv | 47 ++++
 rtl/cpu_step_ctrl.sv | 125 ++++++++++++
 tb/tb_cpu_step_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the run/step/breakpoint controller: state encodings
// (also decoded by the debug select mux) and debounced-input indices.
package cpu_step_ctrl_pkg;

    localparam int PC_W        = 32;
    localparam int N_DB_INPUTS = 2;
    localparam int IDX_BTN     = 0;
    localparam int IDX_RUN     = 1;

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_STEP  = 2'b01,
        S_RUN   = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    // The processor is stopped in both the idle halt and the breakpoint hold.
    function automatic logic is_halted(state_t s);
        return (s == S_HALT) || (s == S_BREAK);
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Board/processor-facing signal bundle of the step controller.
// The slave side is the controller; the master side is whoever drives the
// buttons, breakpoint settings and PC (board glue or a testbench).
interface cpu_step_ctrl_if
    import cpu_step_ctrl_pkg::*;
#(
    parameter int ICNT_W = 32
) ();

    logic              btn_step;
    logic              sw_run;
    logic              bp_enable;
    logic [PC_W-1:0]   bp_addr;
    logic [PC_W-1:0]   pc_value;
    logic              cpu_en;
    logic              halted;
    logic              at_break;
    logic [1:0]        fsm_state;
    logic [ICNT_W-1:0] instr_count;

    modport slave (
        input  btn_step, sw_run, bp_enable, bp_addr, pc_value,
        output cpu_en, halted, at_break, fsm_state, instr_count
    );

    modport master (
        output btn_step, sw_run, bp_enable, bp_addr, pc_value,
        input  cpu_en, halted, at_break, fsm_state, instr_count
    );

endinterface

// File: rtl/cpu_step_ctrl_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer.
// The stable output only follows the synced input after it has differed from
// the current stable value for DEBOUNCE_CYCLES consecutive cycles.
module cpu_step_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_CNT_W        = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_stable
);

    logic [1:0]          r_sync;
    logic [DB_CNT_W-1:0] r_cnt;
    logic                r_stable;
    logic                w_synced;

    assign w_synced = r_sync[1];
    assign o_stable = r_stable;

    // Bring the asynchronous raw input into the clock domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Any agreement with the stable value restarts the count, so bounces
    // shorter than the window never reach the output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (w_synced == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= w_synced;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + DB_CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint controller sitting in front of the processor.
// cpu_en gates PC, register file and DMEM writes; the clock itself is never
// gated. Status and instruction count feed the debug display mux.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_CNT_W        = 20,
    parameter int ICNT_W          = 32
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset,
    cpu_step_ctrl_if.slave  bus
);

    logic [N_DB_INPUTS-1:0] w_raw;
    logic [N_DB_INPUTS-1:0] w_stable;
    logic                   w_btn_db;
    logic                   w_run_db;
    logic                   r_btn_prev;
    logic                   w_step_pulse;
    logic                   w_bp_hit;
    logic                   w_cpu_en;
    state_t                 r_state;
    state_t                 w_state_next;
    logic [ICNT_W-1:0]      r_icnt;

    assign w_raw[IDX_BTN] = bus.btn_step;
    assign w_raw[IDX_RUN] = bus.sw_run;

    genvar gi;
    generate
        for (gi = 0; gi < N_DB_INPUTS; gi++) begin : g_db
            cpu_step_ctrl_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .DB_CNT_W        (DB_CNT_W)
            ) u_db (
                .i_clk    (SYS_clk),
                .i_rst    (SYS_reset),
                .i_raw    (w_raw[gi]),
                .o_stable (w_stable[gi])
            );
        end
    endgenerate

    assign w_btn_db = w_stable[IDX_BTN];
    assign w_run_db = w_stable[IDX_RUN];

    // Previous stable button level; cleared by reset so a button held
    // through reset release still yields exactly one step once debounced.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_btn_prev <= 1'b0;
        end else begin
            r_btn_prev <= w_btn_db;
        end
    end

    assign w_step_pulse = w_btn_db & ~r_btn_prev;
    assign w_bp_hit     = bus.bp_enable & (bus.pc_value == bus.bp_addr);

    // State register; reset parks the controller in halt immediately.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: run beats step in halt, step is ignored while running,
    // and a step out of break deliberately skips the breakpoint compare.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HALT: begin
                if (w_run_db) begin
                    w_state_next = S_RUN;
                end else if (w_step_pulse) begin
                    w_state_next = S_STEP;
                end
            end
            S_STEP: begin
                w_state_next = S_HALT;
            end
            S_RUN: begin
                if (!w_run_db) begin
                    w_state_next = S_HALT;
                end else if (w_bp_hit) begin
                    w_state_next = S_BREAK;
                end
            end
            S_BREAK: begin
                if (!w_run_db) begin
                    w_state_next = S_HALT;
                end else if (w_step_pulse) begin
                    w_state_next = S_STEP;
                end
            end
            default: begin
                w_state_next = S_HALT;
            end
        endcase
    end

    // Combinational so the instruction at the breakpoint never executes on
    // the hit cycle itself.
    assign w_cpu_en = (r_state == S_STEP) | ((r_state == S_RUN) & ~w_bp_hit);

    // Executed-instruction counter, wraps freely.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_icnt <= '0;
        end else if (w_cpu_en) begin
            r_icnt <= r_icnt + ICNT_W'(1);
        end
    end

    assign bus.cpu_en      = w_cpu_en;
    assign bus.halted      = is_halted(r_state);
    assign bus.at_break    = (r_state == S_BREAK);
    assign bus.fsm_state   = r_state;
    assign bus.instr_count = r_icnt;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl with a short debounce window.
// A simple processor model advances the PC by 4 after every cpu_en cycle;
// each expected executed PC is queued when stimulus is applied and popped
// whenever the DUT asserts cpu_en.
module tb_cpu_step_ctrl;
    import cpu_step_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_step_ctrl_if #(.ICNT_W(32)) bus  ();
    cpu_step_ctrl_if #(.ICNT_W(4))  bus4 ();

    assign bus4.btn_step  = bus.btn_step;
    assign bus4.sw_run    = bus.sw_run;
    assign bus4.bp_enable = bus.bp_enable;
    assign bus4.bp_addr   = bus.bp_addr;
    assign bus4.pc_value  = bus.pc_value;

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(4), .DB_CNT_W(3), .ICNT_W(32)) u_dut (
        .SYS_clk   (clk),
        .SYS_reset (rst),
        .bus       (bus.slave)
    );

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(4), .DB_CNT_W(3), .ICNT_W(4)) u_dut4 (
        .SYS_clk   (clk),
        .SYS_reset (rst),
        .bus       (bus4.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          exp_count = 0;
    logic        last_en   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: PC advance after the edge, then sample on the falling edge.
    task automatic cyc();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (last_en) bus.pc_value = bus.pc_value + 32'd4;
        @(negedge clk);
        last_en = bus.cpu_en;
        if (bus.cpu_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_cpu_en", bus.pc_value, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("exec_pc", bus.pc_value, e);
                $display("exec pc=0x%08h count=%0d", bus.pc_value, bus.instr_count);
            end
        end
    endtask

    task automatic expect_pcs(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
        exp_count += n;
    endtask

    task automatic wait_state(input state_t s, input int max_cyc, input string tag);
        int n = 0;
        while (bus.fsm_state !== s && n < max_cyc) begin
            cyc();
            n++;
        end
        chk(tag, 32'(bus.fsm_state), 32'(s));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        last_en = 1'b0;
        repeat (3) cyc();
        bus.pc_value = 32'h0;
        exp_q.delete();
        exp_count = 0;
        rst = 1'b0;
    endtask

    task automatic press_step(input int hold, input int rel);
        bus.btn_step = 1'b1;
        repeat (hold) cyc();
        bus.btn_step = 1'b0;
        repeat (rel) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_step  = 1'b0;
        bus.sw_run    = 1'b0;
        bus.bp_enable = 1'b0;
        bus.bp_addr   = 32'h0;
        bus.pc_value  = 32'h0;

        // 1. reset state
        repeat (2) cyc();
        chk("rst_cpu_en", 32'(bus.cpu_en), 0);
        chk("rst_halted", 32'(bus.halted), 1);
        chk("rst_at_break", 32'(bus.at_break), 0);
        do_reset();
        repeat (2) cyc();
        chk("post_rst_state", 32'(bus.fsm_state), 32'(S_HALT));
        chk("post_rst_icnt", bus.instr_count, 0);
        chk("post_rst_cpu_en", 32'(bus.cpu_en), 0);

        // 2. single steps: one long press, then two more
        expect_pcs(bus.pc_value, 1);
        press_step(20, 20);
        chk("step1_q_empty", 32'(exp_q.size()), 0);
        chk("step1_icnt", bus.instr_count, 32'(exp_count));
        chk("step1_state", 32'(bus.fsm_state), 32'(S_HALT));
        for (int k = 0; k < 2; k++) begin
            expect_pcs(bus.pc_value, 1);
            press_step(20, 20);
        end
        chk("step3_icnt", bus.instr_count, 3);
        chk("step3_pc", bus.pc_value, 32'hC);

        // 3. bouncing button then hold -> one step only
        expect_pcs(bus.pc_value, 1);
        for (int k = 0; k < 4; k++) begin
            bus.btn_step = (k % 2 == 0);
            repeat (2) cyc();
        end
        press_step(20, 20);
        chk("bounce_icnt", bus.instr_count, 4);
        chk("bounce_q_empty", 32'(exp_q.size()), 0);

        // 4. run into a breakpoint at 0x10, step past it, break again at 0x20
        do_reset();
        bus.bp_enable = 1'b1;
        bus.bp_addr   = 32'h10;
        bus.sw_run    = 1'b1;
        expect_pcs(32'h0, 4);
        wait_state(S_BREAK, 40, "wait_break1");
        chk("bp1_pc", bus.pc_value, 32'h10);
        chk("bp1_cpu_en", 32'(bus.cpu_en), 0);
        chk("bp1_at_break", 32'(bus.at_break), 1);
        chk("bp1_halted", 32'(bus.halted), 1);
        chk("bp1_icnt", bus.instr_count, 4);
        chk("bp1_q_empty", 32'(exp_q.size()), 0);
        bus.bp_addr = 32'h20;
        expect_pcs(32'h10, 4);
        bus.btn_step = 1'b1;
        wait_state(S_STEP, 40, "wait_step_from_break");
        wait_state(S_RUN, 5, "wait_resume_run");
        chk("resume_pc", bus.pc_value, 32'h14);
        wait_state(S_BREAK, 40, "wait_break2");
        chk("bp2_pc", bus.pc_value, 32'h20);
        chk("bp2_icnt", bus.instr_count, 8);
        chk("bp2_q_empty", 32'(exp_q.size()), 0);
        bus.btn_step = 1'b0;
        repeat (12) cyc();
        chk("bp2_hold_state", 32'(bus.fsm_state), 32'(S_BREAK));

        // 5. asynchronous reset in the middle of a run
        bus.bp_addr = 32'h20 + 32'(4 * 30);
        expect_pcs(32'h20, 31);
        bus.btn_step = 1'b1;
        wait_state(S_RUN, 40, "wait_run_pre_rst");
        repeat (3) cyc();
        chk("run_cpu_en_pre_rst", 32'(bus.cpu_en), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cpu_en", 32'(bus.cpu_en), 0);
        chk("async_rst_halted", 32'(bus.halted), 1);
        chk("async_rst_state", 32'(bus.fsm_state), 32'(S_HALT));
        last_en = 1'b0;
        bus.sw_run = 1'b0;
        repeat (3) cyc();
        bus.pc_value = 32'h0;
        exp_q.delete();
        exp_count = 0;
        expect_pcs(32'h0, 1);
        rst = 1'b0;
        cyc();
        chk("rel_state", 32'(bus.fsm_state), 32'(S_HALT));
        chk("rel_icnt", bus.instr_count, 0);
        // button still held from before reset: exactly one step once debounced
        repeat (20) cyc();
        chk("held_btn_icnt", bus.instr_count, 1);
        chk("held_btn_q_empty", 32'(exp_q.size()), 0);
        bus.btn_step = 1'b0;
        repeat (10) cyc();

        // 6. counter wrap on the 4-bit build: 17 instructions -> 1
        do_reset();
        bus.bp_enable = 1'b1;
        bus.bp_addr   = 32'(4 * 17);
        bus.sw_run    = 1'b1;
        expect_pcs(32'h0, 17);
        wait_state(S_BREAK, 60, "wait_break_wrap");
        chk("wrap_icnt4", 32'(bus4.instr_count), 1);
        chk("wrap_icnt32", bus.instr_count, 17);
        chk("wrap_q_empty", 32'(exp_q.size()), 0);
        bus.sw_run = 1'b0;
        repeat (12) cyc();
        chk("run_off_state", 32'(bus.fsm_state), 32'(S_HALT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
